int_alu_seq: RTL and testbench

- Parametrised integer/logic ALU for the Hans processor, successor to the fixed-width 32-bit integer path.
- Executes single-cycle ops plus iterative divide/modulo (signed and unsigned) and integer square root in-house; float operations are not handled here.
- Replaces the countdown-style "finished" signal with valid/ready handshakes on both input and output.
- Sits between decode/register-read and writeback; the processor stalls on In_ready/Out_valid.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/int_divider_iter.sv | 67 ++++++
 rtl/int_alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_int_alu_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Op codes, FSM state encoding and op-class helpers shared by the integer ALU and the decoder.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_SQRT = 6'b000011;
  localparam logic [5:0] OP_DIV  = 6'b000100;
  localparam logic [5:0] OP_MOD  = 6'b000101;
  localparam logic [5:0] OP_AND  = 6'b000110;
  localparam logic [5:0] OP_OR   = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLL  = 6'b001001;
  localparam logic [5:0] OP_SRL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SLA  = 6'b001100;
  localparam logic [5:0] OP_SLT  = 6'b001101;
  localparam logic [5:0] OP_SLTU = 6'b001110;
  localparam logic [5:0] OP_SEQ  = 6'b001111;
  localparam logic [5:0] OP_UDIV = 6'b011000;
  localparam logic [5:0] OP_UMOD = 6'b011001;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DIV  = 3'd1;
  localparam logic [2:0] ST_SQRT = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic is_signed_div(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return is_signed_div(op) || (op == OP_UDIV) || (op == OP_UMOD);
  endfunction

  function automatic logic is_mod_op(input logic [5:0] op);
    return (op == OP_MOD) || (op == OP_UMOD);
  endfunction

  function automatic logic is_iterative(input logic [5:0] op);
    return is_div_op(op) || (op == OP_SQRT);
  endfunction

endpackage

// File: rtl/int_divider_iter.sv
// Restoring unsigned divider, one quotient bit per edge, WIDTH edges after start.
// No backpressure: raw quotient/remainder stay valid until the next start.
module int_divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  // When ge holds the true difference is below the divisor, so modular W-bit subtraction is exact.
  assign diff    = shifted[WIDTH-1:0] - dvs_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CW'(WIDTH);
    end else if (busy_o) begin
      rem_d = ge ? diff : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = cnt_q != '0;
  // High during the final iteration: outputs are settled from the following cycle.
  assign done_o = cnt_q == CW'(1);
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/int_alu_seq.sv
// Integer/logic ALU: single-cycle ops latency 1, div/mod WIDTH+2, sqrt WIDTH/2+2 edges from accept.
// Result held in DONE until Out_ready; In_ready only in IDLE or DONE with Out_ready (back-to-back).
module int_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [5:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Div_by_zero,
  output logic             Illegal_op
);

  localparam int HW  = WIDTH / 2;
  localparam int RW  = HW + 2;
  localparam int SCW = $clog2(HW + 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             dbz_q, dbz_d, ill_q, ill_d;
  logic [RW-1:0]    sq_r_q, sq_r_d;
  logic [HW-1:0]    sq_root_q, sq_root_d;
  logic [WIDTH-1:0] sq_a_q, sq_a_d;
  logic [SCW-1:0]   sq_cnt_q, sq_cnt_d;

  logic             accept, div_start, div_busy, div_done;
  logic [WIDTH-1:0] a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix, div_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill, q_neg, r_neg, b_zero;
  logic [RW-1:0]    sq_r_sh, sq_r_next;
  logic [SHAMT_W-1:0] shamt;

  assign In_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && Out_ready);
  assign accept   = In_valid && In_ready;

  assign a_mag     = (is_signed_div(Op) && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag     = (is_signed_div(Op) && B[WIDTH-1]) ? (~B + 1'b1) : B;
  assign div_start = accept && is_div_op(Op) && !div_busy;

  int_divider_iter #(.WIDTH(WIDTH)) u_div (
    .Clock      (Clock),
    .Reset      (Reset),
    .start_i    (div_start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  assign q_neg   = is_signed_div(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg   = is_signed_div(op_q) && a_q[WIDTH-1];
  assign quo_fix = q_neg ? (~div_quo + 1'b1) : div_quo;
  assign rem_fix = r_neg ? (~div_rem + 1'b1) : div_rem;
  assign b_zero  = b_q == '0;
  assign div_res = is_mod_op(op_q) ? (b_zero ? a_q : rem_fix) : (b_zero ? '1 : quo_fix);

  // Non-restoring root step: bring down two radicand bits, add or subtract the trial term.
  assign sq_r_sh   = (sq_r_q << 2) | {{(RW-2){1'b0}}, sq_a_q[WIDTH-1 -: 2]};
  assign sq_r_next = sq_r_q[RW-1] ? (sq_r_sh + {sq_root_q, 2'b11})
                                  : (sq_r_sh - {sq_root_q, 2'b01});

  assign shamt = B[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (Op)
      OP_ADD:           alu_res = A + B;
      OP_SUB:           alu_res = A - B;
      OP_MUL:           alu_res = A * B;
      OP_AND:           alu_res = A & B;
      OP_OR:            alu_res = A | B;
      OP_XOR:           alu_res = A ^ B;
      OP_SLL, OP_SLA:   alu_res = A << shamt;
      OP_SRL:           alu_res = A >> shamt;
      OP_SRA:           alu_res = $unsigned($signed(A) >>> shamt);
      OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:          alu_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SEQ:           alu_res = {{(WIDTH-1){1'b0}}, A == B};
      OP_SQRT, OP_DIV, OP_MOD, OP_UDIV, OP_UMOD: alu_res = '0;
      default:          alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    ill_d     = ill_q;
    sq_r_d    = sq_r_q;
    sq_root_d = sq_root_q;
    sq_a_d    = sq_a_q;
    sq_cnt_d  = sq_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          op_d  = Op;
          a_d   = A;
          b_d   = B;
          dbz_d = 1'b0;
          ill_d = 1'b0;
          if (is_div_op(Op)) begin
            state_d = ST_DIV;
          end else if (Op == OP_SQRT) begin
            state_d   = ST_SQRT;
            sq_r_d    = '0;
            sq_root_d = '0;
            sq_a_d    = A;
            sq_cnt_d  = SCW'(HW);
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            ill_d    = alu_ill;
          end
        end else if ((state_q == ST_DONE) && Out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: if (div_done) state_d = ST_FIX;
      ST_SQRT: begin
        sq_r_d    = sq_r_next;
        sq_root_d = {sq_root_q[HW-2:0], ~sq_r_next[RW-1]};
        sq_a_d    = sq_a_q << 2;
        sq_cnt_d  = sq_cnt_q - 1'b1;
        if (sq_cnt_q == SCW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (op_q == OP_SQRT) begin
          result_d = {{(WIDTH-HW){1'b0}}, sq_root_q};
        end else begin
          result_d = div_res;
          dbz_d    = b_zero;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      ill_q     <= 1'b0;
      sq_r_q    <= '0;
      sq_root_q <= '0;
      sq_a_q    <= '0;
      sq_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      ill_q     <= ill_d;
      sq_r_q    <= sq_r_d;
      sq_root_q <= sq_root_d;
      sq_a_q    <= sq_a_d;
      sq_cnt_q  <= sq_cnt_d;
    end
  end

  assign Out_valid   = state_q == ST_DONE;
  assign Result      = result_q;
  assign Div_by_zero = dbz_q;
  assign Illegal_op  = ill_q;

endmodule

// File: tb/tb_int_alu_seq.sv
// Directed bench for int_alu_seq at WIDTH=32 and WIDTH=16 with a queue of expected results.
module tb_int_alu_seq;

  logic        Clock, Reset;
  logic [5:0]  op;
  logic [31:0] a, b;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, dbz32, ill32;
  logic [31:0] result32;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, dbz16, ill16;
  logic [15:0] result16;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ill;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  int_alu_seq #(.WIDTH(32)) dut32 (
    .Clock(Clock), .Reset(Reset), .In_valid(in_valid32), .In_ready(in_ready32),
    .Op(op), .A(a), .B(b), .Out_valid(out_valid32), .Out_ready(out_ready32),
    .Result(result32), .Div_by_zero(dbz32), .Illegal_op(ill32)
  );

  int_alu_seq #(.WIDTH(16)) dut16 (
    .Clock(Clock), .Reset(Reset), .In_valid(in_valid16), .In_ready(in_ready16),
    .Op(op), .A(a[15:0]), .B(b[15:0]), .Out_valid(out_valid16), .Out_ready(out_ready16),
    .Result(result16), .Div_by_zero(dbz16), .Illegal_op(ill16)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_rdy(input bit w16);
    return w16 ? in_ready16 : in_ready32;
  endfunction

  function automatic logic sel_ov(input bit w16);
    return w16 ? out_valid16 : out_valid32;
  endfunction

  // Offer one op, wait for its result, compare against the queued expectation. Leaves result in DONE.
  task automatic issue(input bit w16, input logic [5:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] er, input logic ed, input logic ei, input int lat, input string tag);
    exp_t e;
    int   n;
    exp_q.push_back('{res: er, dbz: ed, ill: ei, lat: lat});
    op = o; a = aa; b = bb;
    if (w16) begin in_valid16 = 1'b1; out_ready16 = 1'b1; end
    else     begin in_valid32 = 1'b1; out_ready32 = 1'b1; end
    #1;
    n = 0;
    while (!sel_rdy(w16) && n < 200) begin @(posedge Clock); #1; n++; end
    check({tag, " in_ready"}, {31'b0, sel_rdy(w16)}, 32'd1);
    @(posedge Clock); #1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    n = 1;
    while (!sel_ov(w16) && n < 200) begin @(posedge Clock); #1; n++; end
    e = exp_q.pop_front();
    check({tag, " latency"}, n, e.lat);
    if (w16) begin
      check({tag, " result"}, {16'h0, result16}, e.res);
      check({tag, " div_by_zero"}, {31'b0, dbz16}, {31'b0, e.dbz});
      check({tag, " illegal_op"}, {31'b0, ill16}, {31'b0, e.ill});
    end else begin
      check({tag, " result"}, result32, e.res);
      check({tag, " div_by_zero"}, {31'b0, dbz32}, {31'b0, e.dbz});
      check({tag, " illegal_op"}, {31'b0, ill32}, {31'b0, e.ill});
    end
  endtask

  task automatic retire(input bit w16, input string tag);
    if (w16) out_ready16 = 1'b1; else out_ready32 = 1'b1;
    @(posedge Clock); #1;
    out_ready32 = 1'b0; out_ready16 = 1'b0;
    check({tag, " retired"}, {31'b0, sel_ov(w16)}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    op = '0; a = '0; b = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("reset out_valid", {31'b0, out_valid32}, 32'd0);
    check("reset in_ready", {31'b0, in_ready32}, 32'd1);
    check("reset result", result32, 32'd0);
    check("reset flags", {30'b0, dbz32, ill32}, 32'd0);
    check("reset out_valid16", {31'b0, out_valid16}, 32'd0);

    // Back-to-back single-cycle ops: second accept retires the first result.
    issue(1'b0, 6'b000000, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0, 1, "add 7+-3");
    issue(1'b0, 6'b000001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, "sub 0-1");
    retire(1'b0, "sub");
    issue(1'b0, 6'b001011, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1, "sra");
    retire(1'b0, "sra");
    issue(1'b0, 6'b001101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, "slt -1<1");
    retire(1'b0, "slt");

    issue(1'b0, 6'b000100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 34, "div -7/2");
    retire(1'b0, "div");
    issue(1'b0, 6'b000101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, "mod -7/2");
    retire(1'b0, "mod");
    issue(1'b0, 6'b011000, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, 1'b0, 34, "udiv");
    retire(1'b0, "udiv");
    issue(1'b0, 6'b000100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 34, "div 5/0");
    retire(1'b0, "div0");
    issue(1'b0, 6'b000101, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 34, "mod 5/0");
    retire(1'b0, "mod0");
    issue(1'b0, 6'b000100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 34, "div min/-1");
    retire(1'b0, "divmin");

    issue(1'b0, 6'b000011, 32'hFFFF_FFFF, 32'd0, 32'h0000_FFFF, 1'b0, 1'b0, 18, "sqrt max");
    retire(1'b0, "sqrtmax");
    issue(1'b0, 6'b000011, 32'd17, 32'd0, 32'd4, 1'b0, 1'b0, 18, "sqrt 17");
    retire(1'b0, "sqrt17");
    issue(1'b0, 6'b000011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 18, "sqrt 0");
    retire(1'b0, "sqrt0");

    // Output backpressure: result and In_ready hold while Out_ready stays low.
    issue(1'b0, 6'b000100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 34, "div 100/7");
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check("hold result", result32, 32'd14);
      check("hold in_ready", {31'b0, in_ready32}, 32'd0);
      check("hold out_valid", {31'b0, out_valid32}, 32'd1);
    end
    retire(1'b0, "hold");

    // Reset mid-iteration abandons the divide.
    op = 6'b000100; a = 32'd100; b = 32'd7; in_valid32 = 1'b1;
    @(posedge Clock); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("midreset out_valid", {31'b0, out_valid32}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready32}, 32'd1);
    issue(1'b0, 6'b000000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, "add after reset");
    retire(1'b0, "addrst");

    issue(1'b0, 6'b100000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1, "illegal");
    retire(1'b0, "illegal");

    issue(1'b1, 6'b000100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 18, "w16 div 100/7");
    retire(1'b1, "w16div");
    issue(1'b1, 6'b001001, 32'd1, 32'd17, 32'd2, 1'b0, 1'b0, 1, "w16 shl 1<<17");
    retire(1'b1, "w16shl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
